conv_window_sched: RTL and testbench

CONV_WINDOW_SCHED -- requirements
Module: conv_window_sched

---
 rtl/conv_window_sched.sv | 180 ++++++++++++++++++
 tb/tb_conv_window_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sched.sv
// Sequencer for a KxK convolution window sweep: it fetches image columns, fires the
// PE clear/accumulate strobes and hands each window result to a downstream packer.
module conv_window_sched #(
  parameter int K    = 3,
  parameter int IN_H = 16,
  parameter int IN_W = 15
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_req,
  output logic [$clog2(IN_H)-1:0]       rd_row,
  output logic [$clog2(IN_W)-1:0]       rd_col,
  input  logic                          rd_ack,
  output logic                          img_load_en,
  output logic                          pe_clear,
  output logic                          pe_trigger,
  output logic                          pe_sel_neg,
  output logic                          w_shift,
  output logic                          out_valid,
  output logic [$clog2(IN_H-K+1)-1:0]   out_row,
  output logic [$clog2(IN_W-K+1)-1:0]   out_col,
  input  logic                          out_ready
);

  localparam int OUT_H = IN_H - K + 1;
  localparam int OUT_W = IN_W - K + 1;
  localparam int RW    = $clog2(OUT_H);
  localparam int CW    = $clog2(OUT_W);
  localparam int IRW   = $clog2(IN_H);
  localparam int ICW   = $clog2(IN_W);
  localparam int LW    = $clog2(K + 1);

  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_POS,
    S_NEG,
    S_EMIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   out_row_q, out_row_d;
  logic [CW-1:0]   out_col_q, out_col_d;
  logic [LW-1:0]   load_cnt_q, load_cnt_d;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      out_row_q  <= '0;
      out_col_q  <= '0;
      load_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  // Column 0 needs the whole KxK window; later columns slide by one and fetch only the new column.
  always_comb begin
    state_d    = state_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    load_cnt_d = load_cnt_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      out_row_d  = '0;
      out_col_d  = '0;
      load_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_CLR;
            out_row_d = '0;
            out_col_d = '0;
          end
        end
        S_CLR: begin
          state_d    = S_LOAD;
          load_cnt_d = (out_col_q == '0) ? LW'(K) : LW'(1);
        end
        S_LOAD: begin
          if (rd_ack) begin
            load_cnt_d = load_cnt_q - LW'(1);
            if (load_cnt_q == LW'(1)) begin
              state_d = S_POS;
            end
          end
        end
        S_POS: begin
          state_d = S_NEG;
        end
        S_NEG: begin
          state_d = S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (out_col_q != COL_LAST) begin
              out_col_d = out_col_q + CW'(1);
              state_d   = S_CLR;
            end else if (out_row_q != ROW_LAST) begin
              out_col_d = '0;
              out_row_d = out_row_q + RW'(1);
              state_d   = S_CLR;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_d   = S_IDLE;
          out_row_d = '0;
          out_col_d = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    rd_req      = 1'b0;
    rd_row      = '0;
    rd_col      = '0;
    pe_clear    = 1'b0;
    pe_trigger  = 1'b0;
    pe_sel_neg  = 1'b0;
    w_shift     = 1'b0;
    out_valid   = 1'b0;
    out_row     = out_row_q;
    out_col     = out_col_q;
    case (state_q)
      S_CLR: begin
        pe_clear = 1'b1;
      end
      S_LOAD: begin
        rd_req = 1'b1;
        rd_row = IRW'(out_row_q);
        if (out_col_q == '0) begin
          rd_col = ICW'(out_col_q) + ICW'(K) - ICW'(load_cnt_q);
        end else begin
          rd_col = ICW'(out_col_q) + ICW'(K - 1);
        end
      end
      S_POS: begin
        pe_trigger = 1'b1;
      end
      S_NEG: begin
        pe_trigger = 1'b1;
        pe_sel_neg = 1'b1;
        w_shift    = 1'b1;
      end
      S_EMIT: begin
        out_valid = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    img_load_en = rd_req & rd_ack;
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed and randomized checks of conv_window_sched against a transaction-level
// model: expected read-column and window sequences plus stall-adjusted pass length.
module tb_conv_window_sched;

  localparam int K        = 3;
  localparam int IN_H     = 16;
  localparam int IN_W     = 15;
  localparam int OUT_H    = IN_H - K + 1;
  localparam int OUT_W    = IN_W - K + 1;
  localparam int PASS_CYC = OUT_H * (1 + K + 3 + (OUT_W - 1) * 5) + 1;
  localparam int N_WIN    = OUT_H * OUT_W;
  localparam int N_RD     = OUT_H * (K + OUT_W - 1);

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rd_ack = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, done, rd_req, img_load_en, pe_clear, pe_trigger, pe_sel_neg, w_shift, out_valid;
  logic [3:0] rd_row, rd_col, out_row, out_col;

  logic       s_busy, s_done, s_rd_req, s_img, s_clr, s_trig, s_neg, s_wsh, s_ov;
  logic [3:0] s_rrow, s_rcol, s_orow, s_ocol;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_window_sched #(.K(K), .IN_H(IN_H), .IN_W(IN_W)) dut (
    .clk(clk), .rst_ni(rst_ni), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
    .rd_ack(rd_ack), .img_load_en(img_load_en), .pe_clear(pe_clear),
    .pe_trigger(pe_trigger), .pe_sel_neg(pe_sel_neg), .w_shift(w_shift),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs at the falling edge, return just after the rising edge.
  task automatic step(input logic st, input logic ab, input logic ack, input logic rdy);
    start = st; abort = ab; rd_ack = ack; out_ready = rdy;
    @(negedge clk);
    s_busy = busy; s_done = done; s_rd_req = rd_req; s_img = img_load_en; s_clr = pe_clear;
    s_trig = pe_trigger; s_neg = pe_sel_neg; s_wsh = w_shift; s_ov = out_valid;
    s_rrow = rd_row; s_rcol = rd_col; s_orow = out_row; s_ocol = out_col;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strobes();
    return 32'({s_busy, s_done, s_rd_req, s_img, s_clr, s_trig, s_neg, s_wsh, s_ov});
  endfunction

  function automatic logic [31:0] snap_all();
    return 32'({s_busy, s_done, s_rd_req, s_img, s_clr, s_trig, s_neg, s_wsh, s_ov,
                s_rrow, s_rcol, s_orow, s_ocol});
  endfunction

  function automatic logic [31:0] live_all();
    return 32'({busy, done, rd_req, img_load_en, pe_clear, pe_trigger, pe_sel_neg, w_shift,
                out_valid, rd_row, rd_col, out_row, out_col});
  endfunction

  // Runs the pass already in progress until out_valid shows window (r,c), leaving it unaccepted.
  task automatic find_emit(input int r, input int c, output bit found);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (s_ov) begin
        if (s_orow == 4'(r) && s_ocol == 4'(c)) found = 1'b1;
        else step(1'b0, 1'b0, 1'b1, 1'b1);
      end
    end
  endtask

  task automatic run_pass(input int ack_pct, input int rdy_pct, input string tag);
    logic [7:0] exp_rd[$];
    logic [7:0] exp_win[$];
    logic [7:0] last_rd, last_ov, e;
    int stalls = 0, n_clr = 0, n_pos = 0, n_neg = 0, n_img = 0, n_done = 0, n_busy = 0;
    int done_cyc = -1;
    bit pend_rd = 1'b0, pend_ov = 1'b0, ack, rdy;
    for (int r = 0; r < OUT_H; r++) begin
      for (int c = 0; c < OUT_W; c++) begin
        exp_win.push_back({4'(r), 4'(c)});
        if (c == 0) for (int k = 0; k < K; k++) exp_rd.push_back({4'(r), 4'(k)});
        else exp_rd.push_back({4'(r), 4'(c + K - 1)});
      end
    end
    last_rd = '0;
    last_ov = '0;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk({tag, "_idle_at_start"}, 32'(s_busy), 0);
    for (int cyc = 1; cyc < 6000 && done_cyc < 0; cyc++) begin
      ack = (int'($urandom_range(99)) < ack_pct);
      rdy = (int'($urandom_range(99)) < rdy_pct);
      step(1'b0, 1'b0, ack, rdy);
      if (s_busy) n_busy++;
      if (s_clr) n_clr++;
      if (s_trig && !s_neg) n_pos++;
      if (s_trig && s_neg && s_wsh) n_neg++;
      if (pend_rd) chk({tag, "_rd_hold"}, 32'({s_rd_req, s_rrow, s_rcol}), 32'({1'b1, last_rd}));
      if (pend_ov) chk({tag, "_ov_hold"}, 32'({s_ov, s_orow, s_ocol}), 32'({1'b1, last_ov}));
      if (s_rd_req) chk({tag, "_img_en"}, 32'(s_img), 32'(ack));
      if (s_img) begin
        n_img++;
        chk({tag, "_rd_left"}, 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          chk({tag, "_rd_rowcol"}, 32'({s_rrow, s_rcol}), 32'(e));
        end
      end
      if (s_ov && rdy) begin
        chk({tag, "_win_left"}, 32'(exp_win.size() > 0), 1);
        if (exp_win.size() > 0) begin
          e = exp_win.pop_front();
          chk({tag, "_win_rowcol"}, 32'({s_orow, s_ocol}), 32'(e));
        end
      end
      pend_rd = s_rd_req && !ack;
      pend_ov = s_ov && !rdy;
      last_rd = {s_rrow, s_rcol};
      last_ov = {s_orow, s_ocol};
      if (pend_rd || pend_ov) stalls++;
      if (s_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      if (s_done) n_done++;
      if (s_busy) n_busy++;
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(PASS_CYC + stalls));
    chk({tag, "_busy_cycles"}, 32'(n_busy), 32'(PASS_CYC + stalls));
    chk({tag, "_done_count"}, 32'(n_done), 1);
    chk({tag, "_windows_left"}, 32'(exp_win.size()), 0);
    chk({tag, "_img_count"}, 32'(n_img), 32'(N_RD));
    chk({tag, "_clr_count"}, 32'(n_clr), 32'(N_WIN));
    chk({tag, "_pos_count"}, 32'(n_pos), 32'(N_WIN));
    chk({tag, "_neg_count"}, 32'(n_neg), 32'(N_WIN));
    $display("pass %s: windows=%0d reads=%0d stalls=%0d done_cycle=%0d", tag,
             N_WIN - exp_win.size(), n_img, stalls, done_cyc);
  endtask

  initial begin
    bit found;
    int nimg;
    int ndone;

    // Reset asserted: outputs zero, start ignored.
    #2 rst_ni = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_outs_a", snap_all(), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_outs_b", snap_all(), 0);
    rst_ni = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("idle_after_rst", strobes(), 0);

    // First window latency with no stalls.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t0_busy", 32'(s_busy), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t1_clr", 32'({s_busy, s_clr, s_rd_req}), 32'(3'b110));
    for (int i = 0; i < K; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("t_load_req_img", 32'({s_rd_req, s_img}), 32'(2'b11));
      chk("t_load_rowcol", 32'({s_rrow, s_rcol}), 32'({4'd0, 4'(i)}));
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_pos", 32'({s_trig, s_neg, s_wsh}), 32'(3'b100));
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_neg", 32'({s_trig, s_neg, s_wsh}), 32'(3'b111));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t7_out", 32'({s_ov, s_orow, s_ocol}), 32'({1'b1, 8'h00}));
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_in_emit_ov", 32'(s_ov), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("abort_beats_handshake", strobes(), 0);

    // abort alone in IDLE does nothing; start wins over abort.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("idle_abort_noop", strobes(), 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("start_beats_abort", 32'({s_busy, s_clr}), 32'(2'b11));
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("abort_from_clr", strobes(), 0);

    run_pass(100, 100, "clean");
    run_pass(60, 55, "rand_a");
    run_pass(85, 35, "rand_b");

    // rd_ack held low during the second load of window (0,0).
    nimg = 0;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    nimg += int'(s_img);
    chk("stall_first_col", 32'(s_rcol), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      nimg += int'(s_img);
      chk("stall_hold", 32'({s_rd_req, s_rrow, s_rcol}), 32'({1'b1, 4'd0, 4'd1}));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      nimg += int'(s_img);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    nimg += int'(s_img);
    chk("stall_img_count", 32'(nimg), 3);
    chk("stall_window_out", 32'({s_ov, s_orow, s_ocol}), 32'({1'b1, 8'h00}));

    // out_ready held low at window (2,12), then the next row reload.
    find_emit(2, 12, found);
    chk("find_2_12", 32'(found), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("ready_hold", 32'({s_ov, s_orow, s_ocol}), 32'({1'b1, 4'd2, 4'd12}));
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ready_handshake", 32'({s_ov, s_orow, s_ocol}), 32'({1'b1, 4'd2, 4'd12}));
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("wrap_clr", 32'(s_clr), 1);
    for (int i = 0; i < K; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("wrap_reload", 32'({s_img, s_rrow, s_rcol}), 32'({1'b1, 4'd3, 4'(i)}));
    end

    // abort during NEG of window (5,7).
    find_emit(5, 6, found);
    chk("find_5_6", 32'(found), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("w57_clr", 32'(s_clr), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("w57_load", 32'({s_img, s_rrow, s_rcol}), 32'({1'b1, 4'd5, 4'd9}));
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("w57_pos", 32'({s_trig, s_neg}), 32'(2'b10));
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("w57_neg", 32'({s_trig, s_neg, s_wsh}), 32'(3'b111));
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      ndone += int'(s_done);
      if (i == 0) chk("abort_neg_idle", strobes(), 0);
    end
    chk("abort_no_done", 32'(ndone), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("restart_clr", 32'(s_clr), 1);
    for (int i = 0; i < K; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("restart_load", 32'({s_img, s_rrow, s_rcol}), 32'({1'b1, 4'd0, 4'(i)}));
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("restart_out", 32'({s_ov, s_orow, s_ocol}), 32'({1'b1, 8'h00}));
    step(1'b0, 1'b1, 1'b1, 1'b1);

    // Reset asserted mid-LOAD.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_load", 32'(s_rd_req), 1);
    rd_ack = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_outs", live_all(), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_hold_a", snap_all(), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_hold_b", snap_all(), 0);
    rst_ni = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_release_idle", strobes(), 0);
    run_pass(90, 80, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
